instruction_encoder: RTL and testbench

Assembles complete 32-bit RV32I instruction words from decoded fields plus a full-width immediate. It is the inverse of the immediate generator: it scatters the immediate into the format-specific bit positions and range-checks it. The block feeds the instruction-memory loader in the test/boot path through valid/ready handshakes on both sides. Each emitted word is tagged with a running write address.

---
 rtl/instruction_encoder_pkg.sv | 68 ++++++
 rtl/instruction_encoder_imm_field_packer.sv | 55 +++++
 rtl/instruction_encoder.sv | 162 ++++++++++++++++
 tb/tb_instruction_encoder.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_encoder_pkg.sv
// Shared opcode constants, format codes, FSM states and immediate limits
// for the RV32I instruction encoder.
package instruction_encoder_pkg;

    // Base RV32I major opcodes
    localparam logic [6:0] OP_LOAD      = 7'b0000011;
    localparam logic [6:0] OP_STORE     = 7'b0100011;
    localparam logic [6:0] OP_BRANCH    = 7'b1100011;
    localparam logic [6:0] OP_JALR      = 7'b1100111;
    localparam logic [6:0] OP_JAL       = 7'b1101111;
    localparam logic [6:0] OP_ARITH_IMM = 7'b0010011;
    localparam logic [6:0] OP_ARITH     = 7'b0110011;
    localparam logic [6:0] OP_LUI       = 7'b0110111;
    localparam logic [6:0] OP_AUIPC     = 7'b0010111;

    // funct3 values that select the shift-immediate layout
    localparam logic [2:0] FUNCT3_SLL = 3'b001;
    localparam logic [2:0] FUNCT3_SRL = 3'b101;

    // addi x0,x0,0 -- emitted in place of any rejected request
    localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0013;

    // Legal immediate ranges, as signed 32-bit values
    localparam int signed SHAMT_MIN = 0;
    localparam int signed SHAMT_MAX = 31;
    localparam int signed IMM12_MIN = -2048;
    localparam int signed IMM12_MAX = 2047;
    localparam int signed IMMB_MIN  = -4096;
    localparam int signed IMMB_MAX  = 4094;
    localparam int signed IMMJ_MIN  = -1048576;
    localparam int signed IMMJ_MAX  = 1048574;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_SH,
        FMT_S,
        FMT_B,
        FMT_J,
        FMT_U,
        FMT_BAD
    } fmt_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ENCODE,
        ST_EMIT
    } state_e;

    // Classify a request into its packing format; unknown opcodes give FMT_BAD
    function automatic fmt_e fmt_of(input logic [6:0] opcode, input logic [2:0] funct3);
        fmt_e fmt;
        case (opcode)
            OP_ARITH:     fmt = FMT_R;
            OP_ARITH_IMM: fmt = (funct3 == FUNCT3_SLL || funct3 == FUNCT3_SRL) ? FMT_SH : FMT_I;
            OP_LOAD:      fmt = FMT_I;
            OP_JALR:      fmt = FMT_I;
            OP_STORE:     fmt = FMT_S;
            OP_BRANCH:    fmt = FMT_B;
            OP_JAL:       fmt = FMT_J;
            OP_LUI:       fmt = FMT_U;
            OP_AUIPC:     fmt = FMT_U;
            default:      fmt = FMT_BAD;
        endcase
        return fmt;
    endfunction

endpackage

// File: rtl/instruction_encoder_imm_field_packer.sv
// Scatters a full-width immediate into its format-specific instruction bit
// positions and flags immediates that cannot be represented by that format.
module instruction_encoder_imm_field_packer
    import instruction_encoder_pkg::*;
(
    input  logic [6:0]  opcode_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] imm_i,
    output logic [31:0] imm_bits_o,
    output logic        range_err_o
);

    logic signed [31:0] imm_s;
    fmt_e               fmt;

    assign imm_s = $signed(imm_i);
    assign fmt   = fmt_of(opcode_i, funct3_i);

    // Place immediate bits and range-check per format; R-type and unknown opcodes contribute nothing
    always_comb begin
        imm_bits_o  = '0;
        range_err_o = 1'b0;
        case (fmt)
            FMT_SH: begin
                imm_bits_o  = {7'b0, imm_i[4:0], 20'b0};
                range_err_o = (imm_s < SHAMT_MIN) || (imm_s > SHAMT_MAX);
            end
            FMT_I: begin
                imm_bits_o  = {imm_i[11:0], 20'b0};
                range_err_o = (imm_s < IMM12_MIN) || (imm_s > IMM12_MAX);
            end
            FMT_S: begin
                imm_bits_o  = {imm_i[11:5], 13'b0, imm_i[4:0], 7'b0};
                range_err_o = (imm_s < IMM12_MIN) || (imm_s > IMM12_MAX);
            end
            FMT_B: begin
                imm_bits_o  = {imm_i[12], imm_i[10:5], 13'b0, imm_i[4:1], imm_i[11], 7'b0};
                range_err_o = (imm_s < IMMB_MIN) || (imm_s > IMMB_MAX) || imm_i[0];
            end
            FMT_J: begin
                imm_bits_o  = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], 12'b0};
                range_err_o = (imm_s < IMMJ_MIN) || (imm_s > IMMJ_MAX) || imm_i[0];
            end
            FMT_U: begin
                imm_bits_o  = {imm_i[31:12], 12'b0};
                range_err_o = (imm_i[11:0] != 12'b0);
            end
            default: begin
                imm_bits_o  = '0;
                range_err_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/instruction_encoder.sv
// RV32I instruction encoder: captures a decoded request, builds the 32-bit
// word (or a NOP on rejection) and hands it out tagged with a write address.
module instruction_encoder
    import instruction_encoder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          ERR_CNT_W = 16,
    parameter logic [31:0] NOP_INST  = NOP_INST_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [6:0]           in_opcode,
    input  logic [4:0]           in_rd,
    input  logic [4:0]           in_rs1,
    input  logic [4:0]           in_rs2,
    input  logic [2:0]           in_funct3,
    input  logic [6:0]           in_funct7,
    input  logic [31:0]          in_imm,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_inst,
    output logic [31:0]          out_addr,
    output logic                 out_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    state_e state_q, state_d;

    logic [6:0]  opcode_q;
    logic [4:0]  rd_q, rs1_q, rs2_q;
    logic [2:0]  funct3_q;
    logic [6:0]  funct7_q;
    logic [31:0] imm_q;

    logic [31:0]          out_inst_q, out_inst_d;
    logic                 out_err_q, out_err_d;
    logic                 out_valid_q;
    logic [31:0]          out_addr_q;
    logic [ERR_CNT_W-1:0] err_count_q;

    logic capture_en, encode_en, handshake;

    logic [31:0] imm_bits;
    logic        range_err;
    logic [31:0] field_bits;
    fmt_e        fmt;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic: one pass through ENCODE, then wait in EMIT for the consumer
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (in_valid) state_d = ST_ENCODE;
            ST_ENCODE: state_d = ST_EMIT;
            ST_EMIT:   if (out_valid_q && out_ready) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: handshake and datapath enables decoded from state
    always_comb begin
        in_ready   = (state_q == ST_IDLE);
        capture_en = (state_q == ST_IDLE) && in_valid;
        encode_en  = (state_q == ST_ENCODE);
        handshake  = (state_q == ST_EMIT) && out_valid_q && out_ready;
    end

    // Capture the request fields when accepted; they stay put until the next accept
    always_ff @(posedge clk) begin
        if (reset) begin
            opcode_q <= '0;
            rd_q     <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            funct3_q <= '0;
            funct7_q <= '0;
            imm_q    <= '0;
        end else if (capture_en) begin
            opcode_q <= in_opcode;
            rd_q     <= in_rd;
            rs1_q    <= in_rs1;
            rs2_q    <= in_rs2;
            funct3_q <= in_funct3;
            funct7_q <= in_funct7;
            imm_q    <= in_imm;
        end
    end

    instruction_encoder_imm_field_packer u_packer (
        .opcode_i    (opcode_q),
        .funct3_i    (funct3_q),
        .imm_i       (imm_q),
        .imm_bits_o  (imm_bits),
        .range_err_o (range_err)
    );

    assign fmt = fmt_of(opcode_q, funct3_q);

    // Non-immediate fields for each format; immediate slots are left zero for the packer
    always_comb begin
        field_bits = '0;
        case (fmt)
            FMT_R:   field_bits = {funct7_q, rs2_q, rs1_q, funct3_q, rd_q, opcode_q};
            FMT_SH:  field_bits = {funct7_q, 5'b0, rs1_q, funct3_q, rd_q, opcode_q};
            FMT_I:   field_bits = {12'b0, rs1_q, funct3_q, rd_q, opcode_q};
            FMT_S:   field_bits = {7'b0, rs2_q, rs1_q, funct3_q, 5'b0, opcode_q};
            FMT_B:   field_bits = {7'b0, rs2_q, rs1_q, funct3_q, 5'b0, opcode_q};
            FMT_J:   field_bits = {20'b0, rd_q, opcode_q};
            FMT_U:   field_bits = {20'b0, rd_q, opcode_q};
            default: field_bits = '0;
        endcase
    end

    // Final word: merged fields, or the NOP when the opcode is unknown or the immediate does not fit
    always_comb begin
        out_err_d  = range_err || (fmt == FMT_BAD);
        out_inst_d = out_err_d ? NOP_INST : (field_bits | imm_bits);
    end

    // Output word registers: loaded in ENCODE, held through EMIT backpressure
    always_ff @(posedge clk) begin
        if (reset) begin
            out_inst_q  <= '0;
            out_err_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (encode_en) begin
            out_inst_q  <= out_inst_d;
            out_err_q   <= out_err_d;
            out_valid_q <= 1'b1;
        end else if (handshake) begin
            out_valid_q <= 1'b0;
        end
    end

    // Write address advances on every consumed slot, including NOP slots
    always_ff @(posedge clk) begin
        if (reset)          out_addr_q <= BASE_ADDR;
        else if (handshake) out_addr_q <= out_addr_q + 32'd4;
    end

    // Saturating count of rejected requests, bumped as the word enters EMIT
    always_ff @(posedge clk) begin
        if (reset)
            err_count_q <= '0;
        else if (encode_en && out_err_d && !(&err_count_q))
            err_count_q <= err_count_q + ERR_CNT_W'(1);
    end

    assign out_valid = out_valid_q;
    assign out_inst  = out_inst_q;
    assign out_err   = out_err_q;
    assign out_addr  = out_addr_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_instruction_encoder.sv
// Testbench for instruction_encoder: directed vector table, backpressure and
// reset sequences, and randomized requests against a reference model.
module tb_instruction_encoder;

    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_imm;
    logic        out_valid, out_ready;
    logic [31:0] out_inst, out_addr;
    logic        out_err;
    logic [15:0] err_count;

    instruction_encoder #(
        .BASE_ADDR (BASE),
        .ERR_CNT_W (16),
        .NOP_INST  (NOP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_opcode (in_opcode),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_funct3 (in_funct3),
        .in_funct7 (in_funct7),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_inst  (out_inst),
        .out_addr  (out_addr),
        .out_err   (out_err),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [31:0] inst;
        logic        err;
    } vec_t;

    int          errors = 0;
    int          checks = 0;
    int          txn = 0;
    logic [31:0] exp_addr = BASE;
    int          exp_errcnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                                input logic [31:0] imm, input logic [31:0] inst, input logic err);
        vec_t v;
        v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.f3 = f3; v.f7 = f7;
        v.imm = imm; v.inst = inst; v.err = err;
        return v;
    endfunction

    // Extract bits hi..lo of a signed value using arithmetic shifts and masks
    function automatic longint unsigned fld(input longint x, input int hi, input int lo);
        longint unsigned mask;
        mask = (64'd1 << (hi - lo + 1)) - 64'd1;
        return longint'(x >>> lo) & mask;
    endfunction

    // Reference encoder: range rules as plain signed arithmetic, word as a weighted sum of fields
    function automatic vec_t ref_model(input vec_t v);
        vec_t r;
        longint s;
        longint unsigned w, op, rd, rs1, rs2, f3, f7;
        logic bad;
        r = v;
        s = longint'($signed(v.imm));
        op = 64'(v.op); rd = 64'(v.rd); rs1 = 64'(v.rs1); rs2 = 64'(v.rs2);
        f3 = 64'(v.f3); f7 = 64'(v.f7);
        w = 0; bad = 1'b0;
        case (v.op)
            7'b0110011: w = op + (rd << 7) + (f3 << 12) + (rs1 << 15) + (rs2 << 20) + (f7 << 25);
            7'b0010011, 7'b0000011, 7'b1100111: begin
                if (v.op == 7'b0010011 && (v.f3 == 3'd1 || v.f3 == 3'd5)) begin
                    bad = (s < 0) || (s > 31);
                    w = op + (rd << 7) + (f3 << 12) + (rs1 << 15) + (fld(s, 4, 0) << 20) + (f7 << 25);
                end else begin
                    bad = (s < -2048) || (s > 2047);
                    w = op + (rd << 7) + (f3 << 12) + (rs1 << 15) + (fld(s, 11, 0) << 20);
                end
            end
            7'b0100011: begin
                bad = (s < -2048) || (s > 2047);
                w = op + (fld(s, 4, 0) << 7) + (f3 << 12) + (rs1 << 15) + (rs2 << 20) + (fld(s, 11, 5) << 25);
            end
            7'b1100011: begin
                bad = (s < -4096) || (s > 4094) || (s % 2 != 0);
                w = op + (fld(s, 11, 11) << 7) + (fld(s, 4, 1) << 8) + (f3 << 12) + (rs1 << 15)
                    + (rs2 << 20) + (fld(s, 10, 5) << 25) + (fld(s, 12, 12) << 31);
            end
            7'b1101111: begin
                bad = (s < -1048576) || (s > 1048574) || (s % 2 != 0);
                w = op + (rd << 7) + (fld(s, 19, 12) << 12) + (fld(s, 11, 11) << 20)
                    + (fld(s, 10, 1) << 21) + (fld(s, 20, 20) << 31);
            end
            7'b0110111, 7'b0010111: begin
                bad = (s % 4096 != 0);
                w = op + (rd << 7) + (fld(s, 31, 12) << 12);
            end
            default: bad = 1'b1;
        endcase
        r.err  = bad;
        r.inst = bad ? NOP : w[31:0];
        return r;
    endfunction

    // Present a request in IDLE and confirm the two-edge latency to out_valid
    task automatic issue(input vec_t v);
        chk("in_ready_idle", {31'b0, in_ready}, 32'd1);
        out_ready = 1'b0;
        in_opcode = v.op; in_rd = v.rd; in_rs1 = v.rs1; in_rs2 = v.rs2;
        in_funct3 = v.f3; in_funct7 = v.f7; in_imm = v.imm;
        in_valid  = 1'b1;
        @(posedge clk); @(negedge clk);
        in_valid  = 1'b0;
        in_opcode = 7'($urandom); in_imm = $urandom; in_rd = 5'($urandom);
        chk("valid_after_1_edge", {31'b0, out_valid}, 32'd0);
        chk("in_ready_encode", {31'b0, in_ready}, 32'd0);
        @(posedge clk); @(negedge clk);
        chk("valid_after_2_edges", {31'b0, out_valid}, 32'd1);
    endtask

    // Compare the presented word against expectations
    task automatic check_out(input vec_t v, input string tag);
        if (v.err) exp_errcnt++;
        $display("txn %0d %s: op=%b imm=%h inst=%h err=%0d addr=%h errcnt=%0d",
                 txn, tag, v.op, v.imm, out_inst, out_err, out_addr, err_count);
        txn++;
        chk({tag, "_inst"}, out_inst, v.inst);
        chk({tag, "_err"}, {31'b0, out_err}, {31'b0, v.err});
        chk({tag, "_addr"}, out_addr, exp_addr);
        chk({tag, "_errcnt"}, {16'b0, err_count}, 32'(exp_errcnt));
    endtask

    // Stall for a number of cycles, then accept the word
    task automatic release_out(input int stall, input logic [31:0] inst);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); @(negedge clk);
            chk("stall_valid", {31'b0, out_valid}, 32'd1);
            chk("stall_inst", out_inst, inst);
        end
        out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        out_ready = 1'b0;
        exp_addr = exp_addr + 32'd4;
        chk("valid_cleared", {31'b0, out_valid}, 32'd0);
        chk("addr_advanced", out_addr, exp_addr);
    endtask

    vec_t vecs[$];
    vec_t v, e;
    int   bounds[] = '{0, 31, 32, -1, 2047, 2048, -2048, -2049, 4094, 4095, 4096, -4096,
                       -4098, 1048574, 1048576, -1048576, -1048578, 32'h12345000};
    logic [6:0] ops[] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011,
                          7'b1100011, 7'b1101111, 7'b0110111, 7'b0010111};

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
        in_funct3 = '0; in_funct7 = '0; in_imm = '0;

        vecs.push_back(mk(7'h13, 1, 0, 0, 3'd0, 7'h00, 32'hFFFF_FFFF, 32'hFFF0_0093, 0));
        vecs.push_back(mk(7'h23, 0, 2, 5, 3'd2, 7'h00, 32'd8,         32'h0051_2423, 0));
        vecs.push_back(mk(7'h63, 0, 1, 2, 3'd0, 7'h00, 32'hFFFF_FFFC, 32'hFE20_8EE3, 0));
        vecs.push_back(mk(7'h63, 0, 1, 2, 3'd0, 7'h00, 32'd3,         NOP,           1));
        vecs.push_back(mk(7'h6F, 1, 0, 0, 3'd0, 7'h00, 32'h0010_0000, NOP,           1));
        vecs.push_back(mk(7'h6F, 1, 0, 0, 3'd0, 7'h00, 32'h0000_0800, 32'h0010_00EF, 0));
        vecs.push_back(mk(7'h37, 3, 0, 0, 3'd0, 7'h00, 32'h1234_5000, 32'h1234_51B7, 0));
        vecs.push_back(mk(7'h37, 3, 0, 0, 3'd0, 7'h00, 32'h1234_5001, NOP,           1));
        vecs.push_back(mk(7'h13, 1, 1, 0, 3'd1, 7'h00, 32'd31,        32'h01F0_9093, 0));
        vecs.push_back(mk(7'h13, 1, 1, 0, 3'd1, 7'h00, 32'd32,        NOP,           1));
        vecs.push_back(mk(7'h33, 3, 1, 2, 3'd0, 7'h00, 32'hDEAD_BEEF, 32'h0020_81B3, 0));
        vecs.push_back(mk(7'h33, 3, 1, 2, 3'd0, 7'h20, 32'hFFFF_FFFF, 32'h4020_81B3, 0));
        vecs.push_back(mk(7'h7F, 3, 1, 2, 3'd0, 7'h00, 32'd0,         NOP,           1));
        vecs.push_back(mk(7'h13, 0, 0, 0, 3'd0, 7'h00, 32'd2047,      32'h7FF0_0013, 0));
        vecs.push_back(mk(7'h13, 0, 0, 0, 3'd0, 7'h00, 32'd2048,      NOP,           1));
        vecs.push_back(mk(7'h13, 0, 0, 0, 3'd0, 7'h00, 32'hFFFF_F800, 32'h8000_0013, 0));
        vecs.push_back(mk(7'h63, 0, 0, 0, 3'd0, 7'h00, 32'd4094,      32'h7E00_0FE3, 0));
        vecs.push_back(mk(7'h63, 0, 0, 0, 3'd0, 7'h00, 32'd4096,      NOP,           1));
        vecs.push_back(mk(7'h63, 0, 0, 0, 3'd0, 7'h00, 32'hFFFF_F000, 32'h8000_0063, 0));
        vecs.push_back(mk(7'h13, 1, 1, 0, 3'd5, 7'h20, 32'd5,         32'h4050_D093, 0));
        vecs.push_back(mk(7'h6F, 0, 0, 0, 3'd0, 7'h00, 32'hFFF0_0000, 32'h8000_006F, 0));
        vecs.push_back(mk(7'h17, 0, 0, 0, 3'd0, 7'h00, 32'hFFFF_F000, 32'hFFFF_F017, 0));
        vecs.push_back(mk(7'h67, 1, 5, 0, 3'd0, 7'h00, 32'hFFFF_FFFF, 32'hFFF2_80E7, 0));
        vecs.push_back(mk(7'h03, 4, 3, 0, 3'd2, 7'h00, 32'd16,        32'h0101_A203, 0));
        vecs.push_back(mk(7'h13, 1, 1, 0, 3'd1, 7'h00, 32'hFFFF_FFFF, NOP,           1));

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset state
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_inst", out_inst, 32'd0);
        chk("rst_out_err", {31'b0, out_err}, 32'd0);
        chk("rst_out_addr", out_addr, BASE);
        chk("rst_err_count", {16'b0, err_count}, 32'd0);

        // Directed vector table
        foreach (vecs[i]) begin
            issue(vecs[i]);
            check_out(vecs[i], $sformatf("vec%0d", i));
            release_out(0, vecs[i].inst);
        end

        // Backpressure: hold out_ready low with a competing request on the input
        v = mk(7'h23, 0, 2, 5, 3'd2, 7'h00, 32'd8, 32'h0051_2423, 0);
        issue(v);
        check_out(v, "bp");
        in_opcode = 7'h33; in_rd = 5'd9; in_rs1 = 5'd9; in_rs2 = 5'd9; in_imm = 32'd0;
        in_funct3 = 3'd0; in_funct7 = 7'h00;
        in_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); @(negedge clk);
            chk("bp_inst_hold", out_inst, v.inst);
            chk("bp_addr_hold", out_addr, exp_addr);
            chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
            chk("bp_valid_hold", {31'b0, out_valid}, 32'd1);
        end
        in_valid = 1'b0;
        release_out(0, v.inst);
        @(posedge clk); @(negedge clk);
        chk("bp_no_capture", {31'b0, out_valid}, 32'd0);
        v = mk(7'h6F, 1, 0, 0, 3'd0, 7'h00, 32'h0000_0800, 32'h0010_00EF, 0);
        issue(v);
        check_out(v, "bp_next");
        release_out(1, v.inst);

        // Reset while a rejected word is waiting in EMIT
        v = mk(7'h63, 0, 1, 2, 3'd0, 7'h00, 32'd3, NOP, 1);
        issue(v);
        check_out(v, "pre_rst");
        reset = 1'b1;
        @(posedge clk); @(negedge clk);
        reset = 1'b0;
        exp_addr = BASE; exp_errcnt = 0;
        chk("midrst_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst_addr", out_addr, BASE);
        chk("midrst_errcnt", {16'b0, err_count}, 32'd0);
        chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
        v = mk(7'h37, 3, 0, 0, 3'd0, 7'h00, 32'h1234_5000, 32'h1234_51B7, 0);
        issue(v);
        check_out(v, "post_rst");
        release_out(0, v.inst);

        // Randomized requests against the reference model
        for (int n = 0; n < 150; n++) begin
            int mode;
            v.op  = ($urandom_range(0, 9) == 9) ? 7'($urandom) : ops[$urandom_range(0, 8)];
            v.rd  = 5'($urandom); v.rs1 = 5'($urandom); v.rs2 = 5'($urandom);
            v.f3  = 3'($urandom); v.f7 = 7'($urandom);
            mode  = $urandom_range(0, 4);
            case (mode)
                0: v.imm = $urandom;
                1: v.imm = 32'($urandom_range(0, 10000)) - 32'd5000;
                2: v.imm = 32'(bounds[$urandom_range(0, bounds.size() - 1)]);
                3: v.imm = 32'($urandom_range(0, 32'h0040_0000)) - 32'h0020_0000;
                default: v.imm = {20'($urandom), 12'b0};
            endcase
            e = ref_model(v);
            issue(e);
            check_out(e, "rnd");
            release_out($urandom_range(0, 3), e.inst);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
